// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and helpers for the MEM-stage data RAM sequencer.
package mem_ctrl_pkg;

  localparam logic [1:0] MODE_BYTE  = 2'b00;
  localparam logic [1:0] MODE_HALF  = 2'b01;
  localparam logic [1:0] MODE_WORD  = 2'b10;
  localparam logic [1:0] MODE_DWORD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_WAIT0,
    ST_BEAT1,
    ST_WAIT1,
    ST_DONE
  } state_t;

  // Access size in bytes for a request mode.
  function automatic logic [3:0] mode_size(input logic [1:0] mode);
    logic [3:0] size;
    case (mode)
      MODE_BYTE: size = 4'd1;
      MODE_HALF: size = 4'd2;
      MODE_WORD: size = 4'd4;
      default:   size = 4'd8;
    endcase
    return size;
  endfunction

  // Natural alignment: the access size must divide the address.
  function automatic logic mode_aligned(input logic [1:0] mode, input logic [2:0] addr_lo);
    logic ok;
    case (mode)
      MODE_BYTE: ok = 1'b1;
      MODE_HALF: ok = (addr_lo[0] == 1'b0);
      MODE_WORD: ok = (addr_lo[1:0] == 2'b00);
      default:   ok = (addr_lo == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_formatter.sv
// Load data formatter: trims the captured RAM word to the access width and
// zero- or sign-extends it. Word and doubleword beats pass through untouched.
module load_formatter
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [1:0]  mode,
  input  logic        sign_ext,
  output logic [31:0] data_out
);

  // Narrow loads only trust the low lanes of the RAM word.
  always_comb begin
    data_out = word_in;
    case (mode)
      MODE_BYTE: data_out = {{24{sign_ext & word_in[7]}}, word_in[7:0]};
      MODE_HALF: data_out = {{16{sign_ext & word_in[15]}}, word_in[15:0]};
      default:   data_out = word_in;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer between the MEM pipeline stage and the byte-addressed data RAM.
// One request becomes one or two RAM enable pulses, each followed by a wait
// window; the pipeline is stalled until the single-cycle response.
//
// state | meaning
// IDLE  | waiting for req_valid; request checked and latched on accept
// BEAT0 | ram_en high for first (or only) word beat at addr
// WAIT0 | ram_en low, RD_LAT cycles; load data captured on last cycle
// BEAT1 | ram_en high for second doubleword beat at addr+4
// WAIT1 | ram_en low, RD_LAT cycles; second load word captured
// DONE  | resp_valid pulse, stall released, request ignored
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 256,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  input  logic              req_rw,
  input  logic [1:0]        req_mode,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata_lo,
  input  logic [31:0]       req_wdata_hi,
  output logic              stall,
  output logic              resp_valid,
  output logic              resp_fault,
  output logic [31:0]       resp_rdata_lo,
  output logic [31:0]       resp_rdata_hi,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [1:0]        ram_mode,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  // Wait counter reloads to RD_LAT-1 and terminates at zero.
  localparam logic [1:0]      WAIT_LOAD = 2'(RD_LAT - 1);
  localparam logic [ADDR_W:0] LIMIT     = (ADDR_W + 1)'(MEM_BYTES);

  state_t            state;
  logic              l_rw;
  logic [1:0]        l_mode;
  logic              l_signed;
  logic [ADDR_W-1:0] l_addr;
  logic [31:0]       l_wdata_hi;
  logic [31:0]       lo_word;
  logic [1:0]        wait_cnt;
  logic [ADDR_W:0]   end_addr;
  logic              req_fault;
  logic [31:0]       fmt_word;

  // Alignment and range check on the live request (used in the accept cycle).
  always_comb begin
    end_addr  = {1'b0, req_addr} + (ADDR_W + 1)'(mode_size(req_mode));
    req_fault = !mode_aligned(req_mode, req_addr[2:0]) || (end_addr > LIMIT);
  end

  // Stall rises in the accept cycle itself, so it cannot wait for a register;
  // gating with clr keeps it low while reset is held.
  assign stall = clr && ((state == ST_IDLE) ? req_valid : (state != ST_DONE));

  load_formatter u_fmt (
    .word_in  (ram_rdata),
    .mode     (l_mode),
    .sign_ext (l_signed),
    .data_out (fmt_word)
  );

  // Sequencer FSM with registered RAM and response outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state         <= ST_IDLE;
      l_rw          <= 1'b0;
      l_mode        <= MODE_BYTE;
      l_signed      <= 1'b0;
      l_addr        <= '0;
      l_wdata_hi    <= '0;
      lo_word       <= '0;
      wait_cnt      <= '0;
      resp_valid    <= 1'b0;
      resp_fault    <= 1'b0;
      resp_rdata_lo <= '0;
      resp_rdata_hi <= '0;
      ram_en        <= 1'b0;
      ram_rw        <= 1'b0;
      ram_mode      <= MODE_BYTE;
      ram_addr      <= '0;
      ram_wdata     <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            l_rw       <= req_rw;
            l_mode     <= req_mode;
            l_signed   <= req_signed;
            l_addr     <= req_addr;
            l_wdata_hi <= req_wdata_hi;
            if (req_fault) begin
              state         <= ST_DONE;
              resp_valid    <= 1'b1;
              resp_fault    <= 1'b1;
              resp_rdata_lo <= '0;
              resp_rdata_hi <= '0;
            end else begin
              state     <= ST_BEAT0;
              ram_en    <= 1'b1;
              ram_rw    <= req_rw;
              ram_mode  <= (req_mode == MODE_DWORD) ? MODE_WORD : req_mode;
              ram_addr  <= req_addr;
              ram_wdata <= req_wdata_lo;
            end
          end
        end
        ST_BEAT0: begin
          ram_en   <= 1'b0;
          wait_cnt <= WAIT_LOAD;
          state    <= ST_WAIT0;
        end
        ST_WAIT0: begin
          if (wait_cnt != 2'd0) begin
            wait_cnt <= wait_cnt - 2'd1;
          end else if (l_mode == MODE_DWORD) begin
            lo_word   <= l_rw ? 32'd0 : ram_rdata;
            state     <= ST_BEAT1;
            ram_en    <= 1'b1;
            ram_addr  <= l_addr + ADDR_W'(4);
            ram_wdata <= l_wdata_hi;
            ram_mode  <= MODE_WORD;
          end else begin
            state         <= ST_DONE;
            resp_valid    <= 1'b1;
            resp_fault    <= 1'b0;
            resp_rdata_lo <= l_rw ? 32'd0 : fmt_word;
            resp_rdata_hi <= '0;
          end
        end
        ST_BEAT1: begin
          ram_en   <= 1'b0;
          wait_cnt <= WAIT_LOAD;
          state    <= ST_WAIT1;
        end
        ST_WAIT1: begin
          if (wait_cnt != 2'd0) begin
            wait_cnt <= wait_cnt - 2'd1;
          end else begin
            state         <= ST_DONE;
            resp_valid    <= 1'b1;
            resp_fault    <= 1'b0;
            resp_rdata_lo <= lo_word;
            resp_rdata_hi <= l_rw ? 32'd0 : ram_rdata;
          end
        end
        // The request is still held here; accepting it would issue it twice.
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus random
// loads/stores against a byte-array reference memory.
module tb_mem_access_ctrl;

  localparam int ADDR_W    = 32;
  localparam int MEM_BYTES = 256;
  localparam int RD_LAT    = 1;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_rw = 1'b0;
  logic [1:0]  req_mode = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata_lo = '0;
  logic [31:0] req_wdata_hi = '0;
  logic        stall, resp_valid, resp_fault;
  logic [31:0] resp_rdata_lo, resp_rdata_hi;
  logic        ram_en, ram_rw;
  logic [1:0]  ram_mode;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] ram_mem [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];

  mem_access_ctrl #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES), .RD_LAT(RD_LAT)) dut (
    .clk           (clk),
    .clr           (clr),
    .req_valid     (req_valid),
    .req_rw        (req_rw),
    .req_mode      (req_mode),
    .req_signed    (req_signed),
    .req_addr      (req_addr),
    .req_wdata_lo  (req_wdata_lo),
    .req_wdata_hi  (req_wdata_hi),
    .stall         (stall),
    .resp_valid    (resp_valid),
    .resp_fault    (resp_fault),
    .resp_rdata_lo (resp_rdata_lo),
    .resp_rdata_hi (resp_rdata_hi),
    .ram_en        (ram_en),
    .ram_rw        (ram_rw),
    .ram_mode      (ram_mode),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_rdata     (ram_rdata)
  );

  always #5 clk = ~clk;

  // Big-endian RAM; one access per enable pulse. Narrow reads drive junk in
  // the unused upper lanes so missing masking shows up.
  always @(negedge clk) begin : ram_model
    logic [7:0] a;
    if (ram_en) begin
      a = ram_addr[7:0];
      if (ram_rw) begin
        case (ram_mode)
          2'b00: ram_mem[a] = ram_wdata[7:0];
          2'b01: begin
            ram_mem[a]      = ram_wdata[15:8];
            ram_mem[a+8'd1] = ram_wdata[7:0];
          end
          default: begin
            ram_mem[a]      = ram_wdata[31:24];
            ram_mem[a+8'd1] = ram_wdata[23:16];
            ram_mem[a+8'd2] = ram_wdata[15:8];
            ram_mem[a+8'd3] = ram_wdata[7:0];
          end
        endcase
      end else begin
        case (ram_mode)
          2'b00:   ram_rdata = {24'hA5C3E1, ram_mem[a]};
          2'b01:   ram_rdata = {16'h5A3C, ram_mem[a], ram_mem[a+8'd1]};
          default: ram_rdata = {ram_mem[a], ram_mem[a+8'd1], ram_mem[a+8'd2], ram_mem[a+8'd3]};
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rd8(input longint a);
    return ref_mem[a[7:0]];
  endfunction

  function automatic logic [31:0] rd32(input longint a);
    return {rd8(a), rd8(a + 1), rd8(a + 2), rd8(a + 3)};
  endfunction

  // One complete access: drive, check per-cycle stall/enable/response timing
  // against the reference, then confirm nothing happens the cycle after.
  task automatic run_access(input logic rw, input logic [1:0] mode, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wlo,
                            input logic [31:0] whi);
    longint a;
    int size, beats, lat, t, beat;
    logic fault, got, en_exp;
    logic [31:0] exp_lo, exp_hi;
    logic [63:0] sdata;
    a      = longint'(addr);
    size   = 1 << mode;
    fault  = (a % size != 0) || (a + size > MEM_BYTES);
    beats  = fault ? 0 : ((mode == 2'b11) ? 2 : 1);
    lat    = fault ? 1 : beats * (1 + RD_LAT) + 1;
    exp_lo = '0;
    exp_hi = '0;
    if (!fault && !rw) begin
      case (mode)
        2'b00: begin
          exp_lo = {24'h0, rd8(a)};
          if (sgn && exp_lo[7]) exp_lo = exp_lo | 32'hFFFFFF00;
        end
        2'b01: begin
          exp_lo = {16'h0, rd8(a), rd8(a + 1)};
          if (sgn && exp_lo[15]) exp_lo = exp_lo | 32'hFFFF0000;
        end
        2'b10: exp_lo = rd32(a);
        default: begin
          exp_lo = rd32(a);
          exp_hi = rd32(a + 4);
        end
      endcase
    end
    if (!fault && rw) begin
      sdata = (mode == 2'b11) ? {wlo, whi} : {32'h0, wlo};
      for (int i = 0; i < size; i++) ref_mem[8'(a + i)] = 8'(sdata >> (8 * (size - 1 - i)));
    end

    @(posedge clk); #1;
    req_valid    = 1'b1;
    req_rw       = rw;
    req_mode     = mode;
    req_signed   = sgn;
    req_addr     = addr;
    req_wdata_lo = wlo;
    req_wdata_hi = whi;
    got = 1'b0;
    t   = 0;
    while (!got && t <= lat + 4) begin
      @(negedge clk);
      en_exp = (beats > 0) && ((t == 1) || (beats == 2 && t == 2 + RD_LAT));
      chk("stall", stall, t < lat);
      chk("ram_en", ram_en, en_exp);
      if (ram_en) begin
        beat = (t == 1) ? 0 : 1;
        chk("ram_addr", ram_addr, addr + 32'(4 * beat));
        chk("ram_mode", ram_mode, (mode == 2'b11) ? 2'b10 : mode);
        chk("ram_rw", ram_rw, rw);
        chk("ram_wdata", ram_wdata, beat ? whi : wlo);
      end
      chk("resp_valid", resp_valid, t == lat);
      if (resp_valid) begin
        got = 1'b1;
        chk("resp_fault", resp_fault, fault);
        chk("resp_lo", resp_rdata_lo, exp_lo);
        chk("resp_hi", resp_rdata_hi, exp_hi);
      end
      @(posedge clk); #1;
      t++;
    end
    if (!got) chk("resp_timeout", 1'b0, 1'b1);
    req_valid = 1'b0;
    @(negedge clk);
    chk("post_en", ram_en, 1'b0);
    chk("post_valid", resp_valid, 1'b0);
    chk("post_stall", stall, 1'b0);
    chk("hold_lo", resp_rdata_lo, exp_lo);
    chk("hold_hi", resp_rdata_hi, exp_hi);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] preset [8];
    logic [1:0] m;
    logic [31:0] ad;
    preset = '{8'h80, 8'h12, 8'h34, 8'h56, 8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < MEM_BYTES; i++) begin
      ram_mem[i] = 8'($urandom);
      ref_mem[i] = ram_mem[i];
    end
    for (int i = 0; i < 8; i++) begin
      ram_mem[16 + i] = preset[i];
      ref_mem[16 + i] = preset[i];
    end

    // Reset state
    req_valid = 1'b1;
    #23;
    chk("rst_stall", stall, 1'b0);
    chk("rst_en", ram_en, 1'b0);
    chk("rst_valid", resp_valid, 1'b0);
    chk("rst_fault", resp_fault, 1'b0);
    chk("rst_lo", resp_rdata_lo, 32'h0);
    chk("rst_addr", ram_addr, 32'h0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;

    // Directed cases from the access examples
    run_access(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 32'h0);
    chk("sbyte_lo", resp_rdata_lo, 32'hFFFFFF80);
    run_access(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h0);
    chk("ubyte_lo", resp_rdata_lo, 32'h00000080);
    run_access(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0);
    run_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0);
    chk("word_lo", resp_rdata_lo, 32'hDEADBEEF);
    run_access(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0);
    chk("dword_lo", resp_rdata_lo, 32'h80123456);
    chk("dword_hi", resp_rdata_hi, 32'h01020304);
    run_access(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0);
    chk("half_misal", resp_fault, 1'b1);
    run_access(1'b0, 2'b10, 1'b0, 32'hFE, 32'h0, 32'h0);
    chk("word_range", resp_fault, 1'b1);
    run_access(1'b0, 2'b11, 1'b0, 32'hF8, 32'h0, 32'h0);
    chk("dword_top", resp_fault, 1'b0);

    // Reset during the second beat of a doubleword load
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_rw     = 1'b0;
    req_mode   = 2'b11;
    req_signed = 1'b0;
    req_addr   = 32'h10;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_en", ram_en, 1'b1);
    #1;
    clr = 1'b0;
    #1;
    chk("abort_en", ram_en, 1'b0);
    chk("abort_stall", stall, 1'b0);
    chk("abort_valid", resp_valid, 1'b0);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_quiet", resp_valid, 1'b0);
    end
    run_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0);
    chk("after_rst", resp_rdata_lo, 32'h80123456);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      m  = 2'($urandom_range(0, 3));
      ad = ($urandom_range(0, 3) == 0) ? $urandom_range(232, 271) : $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1) ad = ad & ~((32'd1 << m) - 32'd1);
      run_access(1'($urandom_range(0, 1)), m, 1'($urandom_range(0, 1)), ad,
                 $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
